// File: rtl/seq_pipe_pkg.sv
// Shared types for the elastic skid pipeline stage.
// The three-state control encoding is used by the top-level control FSM.
package seq_pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam state_t STATE_RESET = EMPTY;

endpackage

// File: rtl/seq_reg_en.sv
// nbits-wide data register with write enable and synchronous clear to zero.
// Reset has priority over the write enable.
module seq_reg_en #(
    parameter int nbits = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [nbits-1:0] d,
    output logic [nbits-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/seq_pipe_skid_1stage.sv
// Elastic one-stage pipeline register: data and backpressure are both registered,
// with a skid entry absorbing the one item that arrives while in_rdy lags a stall.
module seq_pipe_skid_1stage
    import seq_pipe_pkg::*;
#(
    parameter int nbits = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_val,
    output logic             in_rdy,
    input  logic [nbits-1:0] in_,
    output logic             out_val,
    input  logic             out_rdy,
    output logic [nbits-1:0] out
);

    state_t           state_reg;
    state_t           state_next;
    logic             out_val_reg;
    logic             in_rdy_reg;
    logic             in_fire;
    logic             out_fire;
    logic             main_en;
    logic             skid_en;
    logic [nbits-1:0] main_d;
    logic [nbits-1:0] skid_q;

    // Handshake flags come straight from flops; reset only masks them.
    assign in_rdy   = in_rdy_reg & ~reset;
    assign out_val  = out_val_reg & ~reset;
    assign in_fire  = in_val & in_rdy;
    assign out_fire = out_val & out_rdy;

    always_comb begin
        state_next = state_reg;
        main_en    = 1'b0;
        skid_en    = 1'b0;
        main_d     = in_;
        case (state_reg)
            EMPTY: begin
                if (in_fire) begin
                    main_en    = 1'b1;
                    state_next = ONE;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    main_en = 1'b1;
                end else if (in_fire) begin
                    skid_en    = 1'b1;
                    state_next = FULL;
                end else if (out_fire) begin
                    state_next = EMPTY;
                end
            end
            FULL: begin
                // Upstream is blocked here, so only a drain can move state.
                if (out_fire) begin
                    main_en    = 1'b1;
                    main_d     = skid_q;
                    state_next = ONE;
                end
            end
            default: begin
                state_next = STATE_RESET;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= STATE_RESET;
            out_val_reg <= 1'b0;
            in_rdy_reg  <= 1'b1;
        end else begin
            state_reg   <= state_next;
            out_val_reg <= (state_next != EMPTY);
            in_rdy_reg  <= (state_next != FULL);
        end
    end

    seq_reg_en #(.nbits(nbits)) u_main (
        .clk   (clk),
        .reset (reset),
        .en    (main_en),
        .d     (main_d),
        .q     (out)
    );

    seq_reg_en #(.nbits(nbits)) u_skid (
        .clk   (clk),
        .reset (reset),
        .en    (skid_en),
        .d     (in_),
        .q     (skid_q)
    );

    a_out_val_state: assert property (@(posedge clk) disable iff (reset)
        !out_val |-> (state_reg == EMPTY));
    a_in_rdy_state: assert property (@(posedge clk) disable iff (reset)
        !in_rdy |-> (state_reg == FULL));

endmodule

// File: tb/tb_seq_pipe_skid_1stage.sv
// Randomized and directed bench for the skid stage, checked against a
// two-entry FIFO model whose acceptance window lags by one cycle.
module tb_seq_pipe_skid_1stage;

    localparam int NBITS = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             in_val = 1'b0;
    logic             in_rdy;
    logic [NBITS-1:0] in_ = '0;
    logic             out_val;
    logic             out_rdy = 1'b0;
    logic [NBITS-1:0] out;

    int checks = 0;
    int failures = 0;

    logic [NBITS-1:0] model_q[$];
    logic [NBITS-1:0] popped[$];

    always #5 clk = ~clk;

    seq_pipe_skid_1stage #(.nbits(NBITS)) dut (
        .clk     (clk),
        .reset   (reset),
        .in_val  (in_val),
        .in_rdy  (in_rdy),
        .in_     (in_),
        .out_val (out_val),
        .out_rdy (out_rdy),
        .out     (out)
    );

    // Model: a FIFO of at most two items; upstream may push while fewer than
    // two are held, downstream may pop whenever one is held.
    task automatic tick(input logic v, input logic [NBITS-1:0] d, input logic r);
        logic acc;
        logic pop;
        in_val  = v;
        in_     = d;
        out_rdy = r;
        acc = v && !reset && (model_q.size() < 2);
        pop = r && !reset && (model_q.size() > 0);
        @(posedge clk);
        #1;
        if (reset) begin
            model_q.delete();
        end else begin
            if (pop) popped.push_back(model_q.pop_front());
            if (acc) model_q.push_back(d);
        end
    endtask

    function automatic logic exp_in_rdy();
        return !reset && (model_q.size() < 2);
    endfunction

    function automatic logic exp_out_val();
        return !reset && (model_q.size() > 0);
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick(1'b1, 8'hFF, 1'b1);
            checks++;
            if (in_rdy !== 1'b0 || out_val !== 1'b0) begin
                failures++;
                $display("FAIL reset_hold: in_rdy=%b out_val=%b required 0/0", in_rdy, out_val);
            end
        end
        reset  = 1'b0;
        in_val = 1'b0;
        #1;
        checks++;
        if (out_val !== 1'b0 || in_rdy !== 1'b1 || out !== 8'h00) begin
            failures++;
            $display("FAIL reset_release: out_val=%b in_rdy=%b out=%h required 0/1/00",
                     out_val, in_rdy, out);
        end
        $display("test_reset: done");
    endtask

    task automatic test_single();
        tick(1'b1, 8'h3C, 1'b1);
        checks++;
        if (out_val !== 1'b1 || out !== 8'h3C) begin
            failures++;
            $display("FAIL single_out: out_val=%b out=%h required 1/3c", out_val, out);
        end
        tick(1'b0, 8'h00, 1'b1);
        checks++;
        if (out_val !== 1'b0) begin
            failures++;
            $display("FAIL single_drain: out_val=%b required 0", out_val);
        end
        $display("test_single: sent 3c");
    endtask

    task automatic test_stream();
        for (int i = 1; i <= 8; i++) begin
            tick(1'b1, NBITS'(i), 1'b1);
            checks++;
            if (out_val !== 1'b1 || out !== NBITS'(i) || in_rdy !== 1'b1) begin
                failures++;
                $display("FAIL stream_%0d: out_val=%b out=%h in_rdy=%b required 1/%h/1",
                         i, out_val, out, in_rdy, NBITS'(i));
            end
        end
        tick(1'b0, 8'h00, 1'b1);
        checks++;
        if (out_val !== 1'b0) begin
            failures++;
            $display("FAIL stream_drain: out_val=%b required 0", out_val);
        end
        $display("test_stream: 8 items");
    endtask

    task automatic test_stall();
        logic [NBITS-1:0] want[3];
        want[0] = 8'hA0;
        want[1] = 8'hA1;
        want[2] = 8'hA2;
        popped.delete();
        tick(1'b1, 8'hA0, 1'b1);
        tick(1'b1, 8'hA1, 1'b0);
        checks++;
        if (in_rdy !== 1'b0 || out_val !== 1'b1 || out !== 8'hA0) begin
            failures++;
            $display("FAIL stall_skid: in_rdy=%b out_val=%b out=%h required 0/1/a0",
                     in_rdy, out_val, out);
        end
        tick(1'b1, 8'hA2, 1'b0);
        checks++;
        if (in_rdy !== 1'b0 || out !== 8'hA0) begin
            failures++;
            $display("FAIL stall_hold: in_rdy=%b out=%h required 0/a0", in_rdy, out);
        end
        tick(1'b1, 8'hA2, 1'b1);
        checks++;
        if (in_rdy !== 1'b1 || out_val !== 1'b1 || out !== 8'hA1) begin
            failures++;
            $display("FAIL stall_release: in_rdy=%b out_val=%b out=%h required 1/1/a1",
                     in_rdy, out_val, out);
        end
        tick(1'b1, 8'hA2, 1'b1);
        tick(1'b0, 8'h00, 1'b1);
        tick(1'b0, 8'h00, 1'b1);
        checks++;
        if (popped.size() != 3) begin
            failures++;
            $display("FAIL stall_count: popped=%0d required 3", popped.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (popped[i] !== want[i]) begin
                    failures++;
                    $display("FAIL stall_order_%0d: model=%h required %h", i, popped[i], want[i]);
                end
            end
        end
        checks++;
        if (out_val !== 1'b0) begin
            failures++;
            $display("FAIL stall_empty: out_val=%b required 0", out_val);
        end
        $display("test_stall: a0 a1 a2");
    endtask

    task automatic test_simul_fire();
        tick(1'b1, 8'h55, 1'b0);
        checks++;
        if (out_val !== 1'b1 || out !== 8'h55 || in_rdy !== 1'b1) begin
            failures++;
            $display("FAIL simul_load: out_val=%b out=%h in_rdy=%b required 1/55/1",
                     out_val, out, in_rdy);
        end
        tick(1'b1, 8'hAA, 1'b1);
        checks++;
        if (out_val !== 1'b1 || out !== 8'hAA || in_rdy !== 1'b1) begin
            failures++;
            $display("FAIL simul_fire: out_val=%b out=%h in_rdy=%b required 1/aa/1",
                     out_val, out, in_rdy);
        end
        tick(1'b0, 8'h00, 1'b1);
        $display("test_simul_fire: 55 then aa");
    endtask

    task automatic test_reset_mid();
        tick(1'b1, 8'h11, 1'b0);
        tick(1'b1, 8'h22, 1'b0);
        checks++;
        if (in_rdy !== 1'b0 || out !== 8'h11) begin
            failures++;
            $display("FAIL mid_full: in_rdy=%b out=%h required 0/11", in_rdy, out);
        end
        reset = 1'b1;
        tick(1'b0, 8'h00, 1'b1);
        reset = 1'b0;
        #1;
        checks++;
        if (out_val !== 1'b0 || in_rdy !== 1'b1 || out !== 8'h00) begin
            failures++;
            $display("FAIL mid_release: out_val=%b in_rdy=%b out=%h required 0/1/00",
                     out_val, in_rdy, out);
        end
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, 8'h00, 1'b1);
            checks++;
            if (out_val !== 1'b0) begin
                failures++;
                $display("FAIL mid_leak_%0d: out_val=%b out=%h required out_val 0",
                         i, out_val, out);
            end
        end
        $display("test_reset_mid: discarded 11/22");
    endtask

    task automatic test_random();
        int n_in;
        int n_out;
        n_in  = 0;
        n_out = 0;
        popped.delete();
        for (int c = 0; c < 400; c++) begin
            logic v;
            logic r;
            logic [NBITS-1:0] d;
            v = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 2) != 0);
            d = NBITS'($urandom);
            tick(v, d, r);
            checks++;
            if (in_rdy !== exp_in_rdy() || out_val !== exp_out_val()) begin
                failures++;
                $display("FAIL rand_flags_%0d: in_rdy=%b out_val=%b required %b/%b",
                         c, in_rdy, out_val, exp_in_rdy(), exp_out_val());
            end
            if (model_q.size() > 0) begin
                checks++;
                if (out !== model_q[0]) begin
                    failures++;
                    $display("FAIL rand_data_%0d: out=%h required %h", c, out, model_q[0]);
                end
            end
        end
        n_out = popped.size();
        $display("test_random: 400 cycles, %0d items delivered", n_out);
    endtask

    initial begin
        test_reset();
        test_single();
        test_stream();
        test_stall();
        test_simul_fire();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_pipe_skid_1stage.md
Name: seq_pipe_skid_1stage

Overview:
- Elastic 1-stage pipeline register with val/rdy handshakes on both sides.
- Data moves forward with one cycle of latency, as in the plain delay stage.
- Backpressure (rdy) moves backward and is also registered. No combinational path from out_rdy to in_rdy, or from in_ to out.
- Used between pipeline stages wherever a downstream stall must not feed combinationally into upstream logic.

Parameters:
- nbits, 8, width of the data payload.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- in_val  input  1  upstream asserts when in_ holds valid data.
- in_rdy  output  1  block can accept data this cycle. Driven directly from a flop.
- in_  input  nbits  upstream data.
- out_val  output  1  out holds valid data. Driven directly from a flop.
- out_rdy  input  1  downstream can accept data this cycle.
- out  output  nbits  downstream data. Driven directly from the main data register.

Behaviour:
- Handshake rules:
  - A transfer ("fire") occurs on a cycle where val and rdy on the same side are both 1.
  - in_fire = in_val & in_rdy.
  - out_fire = out_val & out_rdy.
  - in_ is ignored unless in_fire.
  - out is don't-care unless out_val; the bench may still check it.
- Storage:
  - main register: drives out.
  - skid register: holds one extra entry.
- State machine, one state register, 3 states:
  - EMPTY: out_val=0, in_rdy=1.
  - ONE: out_val=1, in_rdy=1; main holds data.
  - FULL: out_val=1, in_rdy=0; main and skid both hold data.
- Transitions, evaluated at posedge:
  - EMPTY, in_fire: main<=in_, go to ONE. Otherwise stay.
  - ONE, in_fire & out_fire: main<=in_, stay ONE.
  - ONE, in_fire & !out_fire: skid<=in_, go to FULL.
  - ONE, !in_fire & out_fire: go to EMPTY; main contents left stale.
  - ONE, neither fires: stay.
  - FULL, out_fire: main<=skid, go to ONE. Otherwise stay. in_fire cannot occur in FULL.
- Latency and throughput:
  - Data accepted at edge N is presented on out after edge N, i.e. 1 cycle, when the block was EMPTY, or in ONE with a simultaneous out_fire.
  - Sustained throughput is 1 transfer/cycle while out_rdy stays 1.
- Ordering: strict FIFO. No data is dropped or duplicated.
- Backpressure:
  - The block absorbs exactly one extra item after out_rdy drops, because in_rdy lags by one cycle.
  - in_rdy returns to 1 the cycle after the FULL-state out_fire.
- Reset:
  - While reset=1, in_rdy and out_val are forced to 0 combinationally.
  - At posedge with reset=1: state<=EMPTY, main<=0, skid<=0.
  - After reset deasserts: out_val=0, in_rdy=1, out=0.
  - A reset mid-operation discards all held data, including data in FULL.
- Widths: no arithmetic; all data paths are nbits wide, with no truncation or extension.
- Invariant (assertion): out_val==0 implies state==EMPTY, and in_rdy==0 implies state==FULL or reset.

Decomposition:
- Shared package seq_pipe_pkg:
  - typedef enum state_t {EMPTY, ONE, FULL}, 2 bits.
  - Constant STATE_RESET = EMPTY.
- Sub-module seq_reg_en:
  - nbits register with synchronous reset to 0 and a write enable.
  - Instantiated twice, for main and skid.
- Control FSM and next-state logic stay in the top module.

Test Plan:
1. Reset: hold reset=1 for 2 cycles with in_val=1, in_=8'hFF. Required: in_rdy=0 and out_val=0 during reset. After release: out_val=0, in_rdy=1, out=8'h00.
2. Single item: in_val=1, in_=8'h3C, out_rdy=1 for 1 cycle. Required: next cycle out_val=1, out=8'h3C; the cycle after that out_val=0.
3. Streaming: send 8'h01..8'h08 back-to-back with out_rdy=1. Required: out shows 8'h01..8'h08 on consecutive cycles, one cycle behind the inputs, with no bubbles.
4. Stall/skid:
   - Stimulus: stream 8'hA0, A1, A2; set out_rdy=0 starting from the cycle A0 appears on out.
   - Required: A1 is accepted into skid; in_rdy=0 the next cycle; A2 is held upstream.
   - Then raise out_rdy. Required: outputs A0, A1, A2 in order, with none lost or duplicated.
5. Simultaneous fire in ONE: with 8'h55 held and out_rdy=1, present in_=8'hAA. Required: state stays ONE and out=8'hAA next cycle.
6. Reset mid-operation: reach FULL holding 8'h11/8'h22, then assert reset for 1 cycle. Required: out_val=0 and in_rdy=1 after release, and neither 8'h11 nor 8'h22 ever appears with out_val=1.
